// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared types and constants for the MIPS control pipeline
package ctrl_pkg;

  localparam int PKG_REG_W   = 5;
  localparam int PKG_ALUOP_W = 2;

  // Main decoder opcodes
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  // ALUOp encodings driven by the main decoder
  localparam logic [PKG_ALUOP_W-1:0] ALUOP_ADD   = 2'b00;
  localparam logic [PKG_ALUOP_W-1:0] ALUOP_SUB   = 2'b01;
  localparam logic [PKG_ALUOP_W-1:0] ALUOP_FUNCT = 2'b10;

  typedef struct packed {
    logic                   valid;
    logic                   reg_dst;
    logic                   branch;
    logic                   mem_read;
    logic                   mem_to_reg;
    logic                   mem_write;
    logic                   alu_src;
    logic                   reg_write;
    logic [PKG_ALUOP_W-1:0] alu_op;
    logic [PKG_REG_W-1:0]   rt;
    logic [PKG_REG_W-1:0]   rd;
  } id_ex_t;

  typedef struct packed {
    logic                 valid;
    logic                 branch;
    logic                 mem_read;
    logic                 mem_write;
    logic                 mem_to_reg;
    logic                 reg_write;
    logic [PKG_REG_W-1:0] dest;
  } ex_mem_t;

  typedef struct packed {
    logic                 valid;
    logic                 mem_to_reg;
    logic                 reg_write;
    logic [PKG_REG_W-1:0] dest;
  } mem_wb_t;

  localparam id_ex_t  ID_EX_BUBBLE  = '0;
  localparam ex_mem_t EX_MEM_BUBBLE = '0;
  localparam mem_wb_t MEM_WB_BUBBLE = '0;

  // Destination register chosen in EX; non-writing instructions carry 0
  function automatic logic [PKG_REG_W-1:0] ex_dest(input id_ex_t s);
    logic [PKG_REG_W-1:0] d;
    d = '0;
    if (s.reg_write) d = s.reg_dst ? s.rd : s.rt;
    return d;
  endfunction

endpackage

// File: rtl/hazard_unit.sv
// rtl/hazard_unit.sv - raw load-use hazard detect between ID and EX
module hazard_unit #(
  parameter int REG_W = 5
) (
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             ex_valid,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rt,
  output logic             load_use
);

  // A load in EX whose target feeds the ID instruction; $0 never creates a dependency
  always_comb begin
    load_use = 1'b0;
    if (id_valid && ex_valid && ex_mem_read && (ex_rt != '0))
      load_use = (ex_rt == id_rs) || (ex_rt == id_rt);
  end

endmodule

// File: rtl/ctrl_pipe.sv
// rtl/ctrl_pipe.sv - ID/EX, EX/MEM, MEM/WB control registers with hazard and flush handling
module ctrl_pipe
  import ctrl_pkg::*;
#(
  parameter int REG_W   = PKG_REG_W,
  parameter int ALUOP_W = PKG_ALUOP_W,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               id_valid,
  input  logic               id_reg_dst,
  input  logic               id_branch,
  input  logic               id_mem_read,
  input  logic               id_mem_to_reg,
  input  logic               id_mem_write,
  input  logic               id_alu_src,
  input  logic               id_reg_write,
  input  logic [ALUOP_W-1:0] id_alu_op,
  input  logic [REG_W-1:0]   id_rs,
  input  logic [REG_W-1:0]   id_rt,
  input  logic [REG_W-1:0]   id_rd,
  input  logic               branch_taken,
  output logic               stall,
  output logic               flush_ifid,
  output logic               ex_valid,
  output logic               ex_reg_dst,
  output logic               ex_alu_src,
  output logic [ALUOP_W-1:0] ex_alu_op,
  output logic [REG_W-1:0]   ex_rt,
  output logic [REG_W-1:0]   ex_rd,
  output logic               mem_valid,
  output logic               mem_branch,
  output logic               mem_mem_read,
  output logic               mem_mem_write,
  output logic [REG_W-1:0]   mem_dest,
  output logic               wb_valid,
  output logic               wb_mem_to_reg,
  output logic               wb_reg_write,
  output logic [REG_W-1:0]   wb_dest,
  output logic [CNT_W-1:0]   stall_count,
  output logic [CNT_W-1:0]   flush_count
);

  id_ex_t  ex_q,  ex_d;
  ex_mem_t mem_q, mem_d;
  mem_wb_t wb_q,  wb_d;
  logic    load_use;
  logic    taken;

  hazard_unit #(.REG_W(REG_W)) u_hazard (
    .id_valid    (id_valid),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .ex_valid    (ex_q.valid),
    .ex_mem_read (ex_q.mem_read),
    .ex_rt       (ex_q.rt),
    .load_use    (load_use)
  );

  // A taken beq in MEM squashes younger work, so it overrides any stall
  assign taken      = mem_q.valid & mem_q.branch & branch_taken;
  assign flush_ifid = taken;
  assign stall      = load_use & ~taken;

  // Next contents of each stage register; bubbles are all-zero
  always_comb begin
    ex_d  = ID_EX_BUBBLE;
    mem_d = EX_MEM_BUBBLE;
    wb_d  = MEM_WB_BUBBLE;

    if (id_valid && !load_use && !taken) begin
      ex_d.valid      = 1'b1;
      // RegDst/MemtoReg are don't-care without RegWrite; gate them to a clean 0
      ex_d.reg_dst    = id_reg_dst & id_reg_write;
      ex_d.mem_to_reg = id_mem_to_reg & id_reg_write;
      ex_d.branch     = id_branch;
      ex_d.mem_read   = id_mem_read;
      ex_d.mem_write  = id_mem_write;
      ex_d.alu_src    = id_alu_src;
      ex_d.reg_write  = id_reg_write;
      ex_d.alu_op     = id_alu_op;
      ex_d.rt         = id_rt;
      ex_d.rd         = id_rd;
    end

    if (ex_q.valid && !taken) begin
      mem_d.valid      = 1'b1;
      mem_d.branch     = ex_q.branch;
      mem_d.mem_read   = ex_q.mem_read;
      mem_d.mem_write  = ex_q.mem_write;
      mem_d.mem_to_reg = ex_q.mem_to_reg;
      mem_d.reg_write  = ex_q.reg_write;
      mem_d.dest       = ex_dest(ex_q);
    end

    if (mem_q.valid) begin
      wb_d.valid      = 1'b1;
      wb_d.mem_to_reg = mem_q.mem_to_reg;
      wb_d.reg_write  = mem_q.reg_write;
      wb_d.dest       = mem_q.dest;
    end
  end

  // Stage registers advance every cycle; reset drops everything in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q  <= ID_EX_BUBBLE;
      mem_q <= EX_MEM_BUBBLE;
      wb_q  <= MEM_WB_BUBBLE;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
    end
  end

  // Saturating event counters; they stick at all-ones rather than wrap
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (stall && (stall_count != {CNT_W{1'b1}}))
        stall_count <= stall_count + CNT_W'(1);
      if (taken && (flush_count != {CNT_W{1'b1}}))
        flush_count <= flush_count + CNT_W'(1);
    end
  end

  assign ex_valid      = ex_q.valid;
  assign ex_reg_dst    = ex_q.reg_dst;
  assign ex_alu_src    = ex_q.alu_src;
  assign ex_alu_op     = ex_q.alu_op;
  assign ex_rt         = ex_q.rt;
  assign ex_rd         = ex_q.rd;
  assign mem_valid     = mem_q.valid;
  assign mem_branch    = mem_q.branch;
  assign mem_mem_read  = mem_q.mem_read;
  assign mem_mem_write = mem_q.mem_write;
  assign mem_dest      = mem_q.dest;
  assign wb_valid      = wb_q.valid;
  assign wb_mem_to_reg = wb_q.mem_to_reg;
  assign wb_reg_write  = wb_q.reg_write;
  assign wb_dest       = wb_q.dest;

endmodule

// File: tb/tb_ctrl_pipe.sv
// tb/tb_ctrl_pipe.sv - scoreboard bench for ctrl_pipe with an instruction-level reference model
module tb_ctrl_pipe;

  localparam int REG_W   = 5;
  localparam int ALUOP_W = 2;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic               clk = 1'b0;
  logic               reset;
  logic               id_valid, id_reg_dst, id_branch, id_mem_read, id_mem_to_reg;
  logic               id_mem_write, id_alu_src, id_reg_write;
  logic [ALUOP_W-1:0] id_alu_op;
  logic [REG_W-1:0]   id_rs, id_rt, id_rd;
  logic               branch_taken;
  logic               stall, flush_ifid;
  logic               ex_valid, ex_reg_dst, ex_alu_src;
  logic [ALUOP_W-1:0] ex_alu_op;
  logic [REG_W-1:0]   ex_rt, ex_rd;
  logic               mem_valid, mem_branch, mem_mem_read, mem_mem_write;
  logic [REG_W-1:0]   mem_dest;
  logic               wb_valid, wb_mem_to_reg, wb_reg_write;
  logic [REG_W-1:0]   wb_dest;
  logic [CNT_W-1:0]   stall_count, flush_count;

  always #5 clk = ~clk;

  ctrl_pipe #(.REG_W(REG_W), .ALUOP_W(ALUOP_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid),
    .id_reg_dst(id_reg_dst), .id_branch(id_branch), .id_mem_read(id_mem_read),
    .id_mem_to_reg(id_mem_to_reg), .id_mem_write(id_mem_write), .id_alu_src(id_alu_src),
    .id_reg_write(id_reg_write), .id_alu_op(id_alu_op),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .branch_taken(branch_taken),
    .stall(stall), .flush_ifid(flush_ifid),
    .ex_valid(ex_valid), .ex_reg_dst(ex_reg_dst), .ex_alu_src(ex_alu_src),
    .ex_alu_op(ex_alu_op), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .mem_valid(mem_valid), .mem_branch(mem_branch), .mem_mem_read(mem_mem_read),
    .mem_mem_write(mem_mem_write), .mem_dest(mem_dest),
    .wb_valid(wb_valid), .wb_mem_to_reg(wb_mem_to_reg), .wb_reg_write(wb_reg_write),
    .wb_dest(wb_dest), .stall_count(stall_count), .flush_count(flush_count)
  );

  typedef enum int {K_NOP, K_R, K_LW, K_SW, K_BEQ} kind_e;
  typedef struct { kind_e kind; logic [REG_W-1:0] rs, rt, rd; } instr_t;
  typedef struct { logic stall, flush; instr_t ex, mem; logic wb_valid; int stall_cnt, flush_cnt; } cyc_t;
  typedef struct { logic mem_to_reg, reg_write; logic [REG_W-1:0] dest; } wb_t;

  cyc_t   cyc_q[$];
  wb_t    wb_q[$];
  instr_t m_ex, m_mem;
  logic   m_wb_valid;
  int     m_sc, m_fc;
  int     errors = 0;
  int     checks = 0;

  function automatic instr_t mk(input kind_e k, input int rs, input int rt, input int rd);
    instr_t i;
    i.kind = k; i.rs = REG_W'(rs); i.rt = REG_W'(rt); i.rd = REG_W'(rd);
    return i;
  endfunction

  function automatic instr_t nop();
    return mk(K_NOP, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31));
  endfunction

  // Architectural destination: rd for R-type, rt for lw, nothing otherwise
  function automatic logic [REG_W-1:0] dest_of(input instr_t i);
    if (i.kind == K_R)  return i.rd;
    if (i.kind == K_LW) return i.rt;
    return '0;
  endfunction

  function automatic logic [ALUOP_W-1:0] alu_op_of(input kind_e k);
    if (k == K_R)   return 2'b10;
    if (k == K_BEQ) return 2'b01;
    return 2'b00;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Main decoder truth table; don't-care outputs are driven with random values
  task automatic drive(input instr_t i, input logic bt);
    id_valid = (i.kind != K_NOP);
    id_rs = i.rs; id_rt = i.rt; id_rd = i.rd;
    branch_taken = bt;
    {id_reg_dst, id_branch, id_mem_read, id_mem_to_reg, id_mem_write, id_alu_src, id_reg_write} = 7'($urandom);
    id_alu_op = 2'($urandom);
    case (i.kind)
      K_R:   begin id_reg_dst = 1; id_alu_src = 0; id_mem_to_reg = 0; id_reg_write = 1;
                   id_mem_read = 0; id_mem_write = 0; id_branch = 0; id_alu_op = 2'b10; end
      K_LW:  begin id_reg_dst = 0; id_alu_src = 1; id_mem_to_reg = 1; id_reg_write = 1;
                   id_mem_read = 1; id_mem_write = 0; id_branch = 0; id_alu_op = 2'b00; end
      K_SW:  begin id_alu_src = 1; id_reg_write = 0; id_mem_read = 0; id_mem_write = 1;
                   id_branch = 0; id_alu_op = 2'b00; end
      K_BEQ: begin id_alu_src = 0; id_reg_write = 0; id_mem_read = 0; id_mem_write = 0;
                   id_branch = 1; id_alu_op = 2'b01; end
      default: ;
    endcase
  endtask

  // One clock: drive, post expectations for this cycle, then advance the model at the edge
  task automatic step(input instr_t i, input logic bt, input logic rst, output logic stl);
    cyc_t r;
    logic taken, raw;
    reset = rst;
    drive(i, bt);
    taken = (m_mem.kind == K_BEQ) && bt;
    raw   = (i.kind != K_NOP) && (m_ex.kind == K_LW) && (m_ex.rt != 0) &&
            ((m_ex.rt == i.rs) || (m_ex.rt == i.rt));
    r.stall = raw && !taken; r.flush = taken;
    r.ex = m_ex; r.mem = m_mem; r.wb_valid = m_wb_valid;
    r.stall_cnt = m_sc; r.flush_cnt = m_fc;
    cyc_q.push_back(r);
    stl = r.stall;
    @(posedge clk);
    if (rst) begin
      m_ex = mk(K_NOP, 0, 0, 0); m_mem = m_ex; m_wb_valid = 0; m_sc = 0; m_fc = 0;
      wb_q.delete();
    end else begin
      m_wb_valid = (m_mem.kind != K_NOP);
      if (m_wb_valid)
        wb_q.push_back('{mem_to_reg: (m_mem.kind == K_LW),
                         reg_write: (m_mem.kind == K_R || m_mem.kind == K_LW),
                         dest: dest_of(m_mem)});
      m_mem = taken ? mk(K_NOP, 0, 0, 0) : m_ex;
      m_ex  = (taken || raw || i.kind == K_NOP) ? mk(K_NOP, 0, 0, 0) : i;
      if (raw && !taken && m_sc < CNT_MAX) m_sc++;
      if (taken && m_fc < CNT_MAX) m_fc++;
    end
    #1;
  endtask

  // Issue an instruction, re-presenting it while IF/ID is held by a stall
  task automatic issue(input instr_t i, input logic bt);
    logic s;
    step(i, bt, 1'b0, s);
    if (s) step(i, 1'b0, 1'b0, s);
  endtask

  // Monitor: compares DUT outputs against the posted expectations and the WB scoreboard
  always @(negedge clk) begin : monitor
    cyc_t r;
    wb_t  w;
    logic ev, mv;
    if (cyc_q.size() > 0) begin
      r  = cyc_q.pop_front();
      ev = (r.ex.kind != K_NOP);
      mv = (r.mem.kind != K_NOP);
      check("stall", stall, r.stall);
      check("flush_ifid", flush_ifid, r.flush);
      check("ex_valid", ex_valid, ev);
      check("ex_reg_dst", ex_reg_dst, r.ex.kind == K_R);
      check("ex_alu_src", ex_alu_src, r.ex.kind == K_LW || r.ex.kind == K_SW);
      check("ex_alu_op", ex_alu_op, alu_op_of(r.ex.kind));
      check("ex_rt", ex_rt, ev ? r.ex.rt : 0);
      check("ex_rd", ex_rd, ev ? r.ex.rd : 0);
      check("mem_valid", mem_valid, mv);
      check("mem_branch", mem_branch, r.mem.kind == K_BEQ);
      check("mem_mem_read", mem_mem_read, r.mem.kind == K_LW);
      check("mem_mem_write", mem_mem_write, r.mem.kind == K_SW);
      check("mem_dest", mem_dest, dest_of(r.mem));
      check("wb_valid", wb_valid, r.wb_valid);
      if (wb_valid) begin
        check("wb_q_nonempty", wb_q.size() > 0, 1);
        if (wb_q.size() > 0) begin
          w = wb_q.pop_front();
          check("wb_mem_to_reg", wb_mem_to_reg, w.mem_to_reg);
          check("wb_reg_write", wb_reg_write, w.reg_write);
          check("wb_dest", wb_dest, w.dest);
        end
      end else begin
        check("wb_bubble", {wb_mem_to_reg, wb_reg_write, wb_dest}, 0);
      end
      check("stall_count", stall_count, r.stall_cnt);
      check("flush_count", flush_count, r.flush_cnt);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    logic   s;
    instr_t cur;
    m_ex = mk(K_NOP, 0, 0, 0); m_mem = m_ex; m_wb_valid = 0; m_sc = 0; m_fc = 0;
    reset = 1'b1;
    drive(nop(), 1'b0);
    @(posedge clk); #1;
    step(nop(), 1'b0, 1'b1, s);

    // R-type rd=5 walks EX -> MEM -> WB
    issue(mk(K_R, 1, 2, 5), 1'b0);
    repeat (4) step(nop(), 1'b0, 1'b0, s);

    // lw rt=8 followed by a consumer of r8
    issue(mk(K_LW, 3, 8, 0), 1'b0);
    issue(mk(K_R, 8, 9, 10), 1'b0);
    repeat (4) step(nop(), 1'b0, 1'b0, s);

    // lw into $0 never stalls
    issue(mk(K_LW, 0, 0, 0), 1'b0);
    issue(mk(K_R, 0, 0, 11), 1'b0);
    repeat (4) step(nop(), 1'b0, 1'b0, s);

    // Taken beq squashes the two younger instructions
    step(mk(K_BEQ, 1, 2, 0), 1'b0, 1'b0, s);
    step(mk(K_R, 3, 4, 6), 1'b0, 1'b0, s);
    step(mk(K_R, 3, 4, 7), 1'b1, 1'b0, s);
    repeat (4) step(nop(), 1'b0, 1'b0, s);

    // Taken beq and load-use in the same cycle: flush wins
    step(mk(K_BEQ, 1, 2, 0), 1'b0, 1'b0, s);
    step(mk(K_LW, 0, 2, 0), 1'b0, 1'b0, s);
    step(mk(K_R, 2, 3, 4), 1'b1, 1'b0, s);
    repeat (4) step(nop(), 1'b0, 1'b0, s);

    // Back-to-back dependent loads: stall counter saturates, then reset mid-stall
    repeat (2 * ((1 << CNT_W) + 5)) step(mk(K_LW, 1, 1, 0), 1'b0, 1'b0, s);
    if (m_ex.kind != K_LW) step(mk(K_LW, 1, 1, 0), 1'b0, 1'b0, s);
    step(mk(K_LW, 1, 1, 0), 1'b0, 1'b1, s);
    step(nop(), 1'b0, 1'b1, s);

    // Randomized instruction mix with small register range to provoke hazards
    repeat (400) begin
      cur = mk(kind_e'($urandom_range(0, 4)), $urandom_range(0, 3), $urandom_range(0, 3),
               $urandom_range(0, 3));
      issue(cur, 1'($urandom_range(0, 1)));
    end
    repeat (4) step(nop(), 1'b0, 1'b0, s);

    @(negedge clk); #1;
    check("wb_q_drained", wb_q.size(), 0);
    check("cyc_q_drained", cyc_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ctrl_pipe.md
Name: ctrl_pipe

Overview:
Receiving end of the main control decoder's output bundle (RegDst, Branch, MemRead, MemtoReg, ALUOp, MemWrite, ALUSrc, RegWrite). Carries decoded control through the ID/EX, EX/MEM and MEM/WB pipeline registers of the 5-stage MIPS datapath. Detects load-use hazards (stall + bubble) and squashes wrong-path stages on a taken beq resolved in MEM. Keeps saturating stall and flush counters.

Parameters:
REG_W, 5, register index width
ALUOP_W, 2, ALUOp width
CNT_W, 16, stall/flush counter width

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
id_valid  input  1  ID stage holds a real instruction
id_reg_dst, id_branch, id_mem_read, id_mem_to_reg, id_mem_write, id_alu_src, id_reg_write  input  1 each  decoder outputs
id_alu_op  input  ALUOP_W  decoder ALUOp
id_rs, id_rt, id_rd  input  REG_W each  instruction register fields
branch_taken  input  1  beq compare result from MEM-stage zero flag
stall  output  1  hold PC and IF/ID this cycle (combinational)
flush_ifid  output  1  squash IF/ID this cycle (combinational)
ex_valid, ex_reg_dst, ex_alu_src  output  1 each  ID/EX register
ex_alu_op  output  ALUOP_W  ID/EX register
ex_rt, ex_rd  output  REG_W each  ID/EX register
mem_valid, mem_branch, mem_mem_read, mem_mem_write  output  1 each  EX/MEM register
mem_dest  output  REG_W  EX/MEM destination
wb_valid, wb_mem_to_reg, wb_reg_write  output  1 each  MEM/WB register
wb_dest  output  REG_W  MEM/WB destination
stall_count, flush_count  output  CNT_W each  saturating event counters

Behaviour:
- Reset (synchronous): every stage register loads BUBBLE (all control, valid, register fields = 0); counters = 0. stall = flush_ifid = 0 whenever all stages hold BUBBLE.
- Bubble is all-zero, never X. When id_valid=0, ID/EX captures BUBBLE. X on don't-care decoder outputs (RegDst/MemtoReg for sw/beq) is forced to 0 on capture.
- Destination is computed in EX: dest = ex_reg_dst ? ex_rd : ex_rt. It is forced to 0 when the instruction's RegWrite=0. The result is captured into mem_dest and then wb_dest.
- Latency: a decoder bundle sampled at edge N appears on ex_* after N, on mem_* after N+1, and on wb_* after N+2.
- Load-use: stall = id_valid & ex_valid & ex_mem_read & (ex_rt != 0) & (ex_rt == id_rs | ex_rt == id_rt). While stall=1, ID/EX loads BUBBLE and EX/MEM and MEM/WB advance normally. Stall is exactly 1 cycle per hazard.
- Taken branch: taken = mem_valid & mem_branch & branch_taken. flush_ifid = taken.
  - On that edge, ID/EX and EX/MEM load BUBBLE.
  - MEM/WB advances normally, so the beq reaches WB with reg_write=0.
- Flush priority: when taken and the stall condition are true in the same cycle, flush wins. stall is driven 0 and stall_count does not increment.
- Counters: stall_count += 1 per stall cycle; flush_count += 1 per taken cycle. Both saturate at all-ones with no wrap.
- Register $0: a hazard match on register 0 never stalls.
- Reset asserted mid-stall or mid-flush: the next edge yields all BUBBLE; pending events are dropped and not counted.

Decomposition:
- Package ctrl_pkg holds:
  - opcode constants: OP_RTYPE=6'b000000, OP_LW=6'b100011, OP_SW=6'b101011, OP_BEQ=6'b000100
  - ALUOp encodings: ADD=2'b00, SUB=2'b01, FUNCT=2'b10
  - packed structs id_ex_t, ex_mem_t, mem_wb_t, each with a BUBBLE constant
- Sub-module hazard_unit: combinational load-use detect producing the raw stall condition.

Test Plan:
- R-type (id_reg_dst=1, id_reg_write=1, id_alu_op=2'b10, rd=5), id_valid=1 for one cycle -> ex_rd=5 next cycle; mem_dest=5 after 2 edges; wb_reg_write=1, wb_dest=5 after 3 edges; stall never 1.
- lw rt=8, then next instruction with rs=8 -> stall=1 for exactly one cycle; ex_valid=0 the following cycle; stall_count=1.
- lw rt=0, then rs=0 -> stall stays 0.
- beq reaches MEM with branch_taken=1 -> flush_ifid=1 that cycle; next cycle ex_valid=0 and mem_valid=0; wb_reg_write=0; flush_count=1.
- Taken branch in MEM while a load-use condition is present in the same cycle -> stall=0 and flush_ifid=1; stall_count unchanged.
- Drive stall continuously for 2^CNT_W+5 cycles (CNT_W=4 in bench) -> stall_count holds at 15 with no wrap; then reset=1 -> all outputs 0 after the next edge.
